// File: rtl/voice_phase_sequencer.sv
// Per-voice phase accumulator with a round-robin READ/UPDATE scheduler.
// Each sample_tick walks every voice once and emits its pre-increment phase to the wavetable stage.
module voice_phase_sequencer #(
    parameter int NUM_VOICES  = 16,
    parameter int ACC_WIDTH   = 24,
    parameter int PHASE_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_tick,
    input  logic                   cfg_we,
    input  logic [7:0]             cfg_voice,
    input  logic [ACC_WIDTH-1:0]   cfg_increment,
    input  logic [3:0]             cfg_wave,
    input  logic                   cfg_gate,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic [3:0]             wave_select,
    output logic [7:0]             voice_index,
    output logic                   voice_valid,
    output logic                   voice_active,
    output logic                   frame_busy,
    output logic                   frame_done,
    output logic                   tick_overrun
);

    localparam int         IDX_W       = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [7:0] LAST_VOICE  = 8'(NUM_VOICES - 1);
    localparam logic [8:0] VOICE_LIMIT = 9'(NUM_VOICES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic [7:0] voice;
    logic [7:0] voice_next;

    logic [ACC_WIDTH-1:0] acc  [NUM_VOICES];
    logic [ACC_WIDTH-1:0] inc  [NUM_VOICES];
    logic [3:0]           wave [NUM_VOICES];
    logic                 gate [NUM_VOICES];

    logic [ACC_WIDTH-1:0] f_acc;
    logic [ACC_WIDTH-1:0] f_inc;
    logic [3:0]           f_wave;
    logic                 f_gate;

    logic [IDX_W-1:0] vi;
    logic [IDX_W-1:0] ci;
    logic             cfg_hit;

    assign vi         = voice[IDX_W-1:0];
    assign ci         = cfg_voice[IDX_W-1:0];
    assign cfg_hit    = cfg_we && ({1'b0, cfg_voice} < VOICE_LIMIT);
    assign frame_busy = (state != IDLE);

    always_comb begin
        state_next = state;
        voice_next = voice;
        unique case (state)
            IDLE: begin
                if (sample_tick) begin
                    state_next = READ;
                    voice_next = '0;
                end
            end
            READ: begin
                state_next = UPDATE;
            end
            UPDATE: begin
                if (voice == LAST_VOICE) begin
                    state_next = IDLE;
                    voice_next = '0;
                end else begin
                    state_next = READ;
                    voice_next = voice + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                voice_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            voice        <= '0;
            f_acc        <= '0;
            f_inc        <= '0;
            f_wave       <= '0;
            f_gate       <= 1'b0;
            phase        <= '0;
            wave_select  <= '0;
            voice_index  <= '0;
            voice_valid  <= 1'b0;
            voice_active <= 1'b0;
            frame_done   <= 1'b0;
            tick_overrun <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                acc[i]  <= '0;
                inc[i]  <= '0;
                wave[i] <= '0;
                gate[i] <= 1'b0;
            end
        end else begin
            state        <= state_next;
            voice        <= voice_next;
            voice_valid  <= 1'b0;
            frame_done   <= 1'b0;
            tick_overrun <= sample_tick && (state != IDLE);

            if (state == READ) begin
                f_acc  <= acc[vi];
                f_inc  <= inc[vi];
                f_wave <= wave[vi];
                f_gate <= gate[vi];
            end

            if (state == UPDATE) begin
                phase        <= f_acc[ACC_WIDTH-1 -: PHASE_WIDTH];
                wave_select  <= f_wave;
                voice_index  <= voice;
                voice_active <= f_gate;
                voice_valid  <= 1'b1;
                frame_done   <= (voice == LAST_VOICE);
                // Live gate is also checked so a gate-clear landing between READ and UPDATE is not undone.
                acc[vi]      <= (f_gate && gate[vi]) ? f_acc + f_inc : '0;
            end

            // Placed after the writeback so a same-edge gate-clear takes priority.
            if (cfg_hit) begin
                inc[ci]  <= cfg_increment;
                wave[ci] <= cfg_wave;
                gate[ci] <= cfg_gate;
                if (!cfg_gate) begin
                    acc[ci] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_voice_phase_sequencer.sv
// Directed bench for voice_phase_sequencer: a frame model pushes expected strobes,
// a negedge monitor pops and compares each voice_valid / tick_overrun it sees.
module tb_voice_phase_sequencer;

    localparam int NV = 16;
    localparam int AW = 24;
    localparam int PW = 10;
    localparam int W  = 40;

    logic          clk = 1'b0;
    logic          reset;
    logic          sample_tick;
    logic          cfg_we;
    logic [7:0]    cfg_voice;
    logic [AW-1:0] cfg_increment;
    logic [3:0]    cfg_wave;
    logic          cfg_gate;
    logic [PW-1:0] phase;
    logic [3:0]    wave_select;
    logic [7:0]    voice_index;
    logic          voice_valid;
    logic          voice_active;
    logic          frame_busy;
    logic          frame_done;
    logic          tick_overrun;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    voice_phase_sequencer #(
        .NUM_VOICES (NV),
        .ACC_WIDTH  (AW),
        .PHASE_WIDTH(PW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .cfg_we       (cfg_we),
        .cfg_voice    (cfg_voice),
        .cfg_increment(cfg_increment),
        .cfg_wave     (cfg_wave),
        .cfg_gate     (cfg_gate),
        .phase        (phase),
        .wave_select  (wave_select),
        .voice_index  (voice_index),
        .voice_valid  (voice_valid),
        .voice_active (voice_active),
        .frame_busy   (frame_busy),
        .frame_done   (frame_done),
        .tick_overrun (tick_overrun)
    );

    // Expected strobe = {cycle[15:0], phase, wave, voice, active, done}
    logic [W-1:0]  exp_q[$];
    int            ovr_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            last_t = 0;

    logic [AW-1:0] m_acc  [NV];
    logic [AW-1:0] m_inc  [NV];
    logic [3:0]    m_wave [NV];
    logic          m_gate [NV];
    logic [PW-1:0] seen_phase [NV];

    function automatic logic [W-1:0] pack(int c, logic [PW-1:0] ph, logic [3:0] wv,
                                          logic [7:0] v, logic act, logic dn);
        return {16'(c), ph, wv, v, act, dn};
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NV; i++) begin
            m_acc[i]  = '0;
            m_inc[i]  = '0;
            m_wave[i] = '0;
            m_gate[i] = 1'b0;
        end
    endtask

    task automatic wait_until(int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Tick in the current cycle; push the first n voices' expected strobes and advance the model.
    task automatic do_tick(int n);
        @(posedge clk);
        #1;
        last_t      = cyc;
        sample_tick = 1'b1;
        for (int k = 0; k < NV; k++) begin
            if (k < n)
                exp_q.push_back(pack(last_t + 3 + 2 * k, m_acc[k][AW-1 -: PW], m_wave[k],
                                     8'(k), m_gate[k], k == NV - 1));
            m_acc[k] = m_gate[k] ? m_acc[k] + m_inc[k] : '0;
        end
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
    endtask

    task automatic model_cfg(logic [7:0] v, logic [AW-1:0] inc, logic [3:0] wv, logic g);
        if (int'(v) < NV) begin
            m_inc[v[3:0]]  = inc;
            m_wave[v[3:0]] = wv;
            m_gate[v[3:0]] = g;
            if (!g) m_acc[v[3:0]] = '0;
        end
    endtask

    task automatic cfg_write(logic [7:0] v, logic [AW-1:0] inc, logic [3:0] wv, logic g);
        @(posedge clk);
        #1;
        cfg_we = 1'b1; cfg_voice = v; cfg_increment = inc; cfg_wave = wv; cfg_gate = g;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        model_cfg(v, inc, wv, g);
    endtask

    task automatic wait_frame();
        int budget = 3 * NV + 10;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_timeout: %0d strobes still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] exp;
        if (!reset && voice_valid) begin
            got = pack(cyc, phase, wave_select, voice_index, voice_active, frame_done);
            seen_phase[voice_index[3:0]] = phase;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL strobe: unexpected voice %0d at cycle %0d, expected none",
                         voice_index, cyc);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL strobe: got cyc %0d ph %0d wave %0d voice %0d act %0d done %0d, expected cyc %0d ph %0d wave %0d voice %0d act %0d done %0d",
                             got[39:24], got[23:14], got[13:10], got[9:2], got[1], got[0],
                             exp[39:24], exp[23:14], exp[13:10], exp[9:2], exp[1], exp[0]);
                end
            end
        end
        if (!reset && frame_done && !voice_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_alone: frame_done=1 with voice_valid=0 at cycle %0d", cyc);
        end
        if (!reset && tick_overrun) begin
            n_cmp++;
            if (ovr_q.size() == 0) begin
                n_bad++;
                $display("FAIL overrun: unexpected pulse at cycle %0d, expected none", cyc);
            end else begin
                int e;
                e = ovr_q.pop_front();
                if (e != cyc) begin
                    n_bad++;
                    $display("FAIL overrun: pulse at cycle %0d, expected %0d", cyc, e);
                end
            end
        end
    end

    initial begin
        int tab3 [5] = '{0, 16, 32, 48, 64};
        int tab0 [5] = '{0, 512, 0, 512, 0};

        reset = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_voice = '0;
        cfg_increment = '0; cfg_wave = '0; cfg_gate = 1'b0;
        model_clear();
        for (int i = 0; i < NV; i++) seen_phase[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("rst_phase", phase, 0);
        check("rst_wave", wave_select, 0);
        check("rst_voice", voice_index, 0);
        check("rst_valid", voice_valid, 0);
        check("rst_active", voice_active, 0);
        check("rst_busy", frame_busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_overrun", tick_overrun, 0);

        // All voices ungated: 16 strobes, phase 0, busy window T+1..T+32.
        do_tick(NV);
        @(negedge clk);
        check("busy_start", frame_busy, 1);
        wait_until(last_t + 2 * NV);
        @(negedge clk);
        check("busy_last", frame_busy, 1);
        wait_until(last_t + 2 * NV + 1);
        @(negedge clk);
        check("busy_end", frame_busy, 0);
        wait_frame();

        // Voice 3 steady ramp and voice 0 wrapping every second frame.
        cfg_write(8'd3, 24'h040000, 4'd1, 1'b1);
        cfg_write(8'd0, 24'h800000, 4'd2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            do_tick(NV);
            wait_frame();
            check("v3_phase", seen_phase[3], tab3[i]);
            check("v0_wrap", seen_phase[0], tab0[i]);
        end

        // Out-of-range voice 19 would alias voice 3 if not dropped.
        cfg_write(8'd19, 24'h000000, 4'hF, 1'b0);
        do_tick(NV);
        wait_frame();
        check("oor_dropped", seen_phase[3], 80);

        // Second tick mid-frame: overrun pulse next cycle, frame untouched.
        do_tick(NV);
        wait_until(last_t + 10);
        sample_tick = 1'b1;
        ovr_q.push_back(last_t + 11);
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        wait_frame();
        check("overrun_seen", ovr_q.size(), 0);

        // Gate-clear on voice 2's UPDATE edge: old phase emitted, silent next frame.
        cfg_write(8'd2, 24'h100000, 4'd5, 1'b1);
        do_tick(NV);
        wait_frame();
        do_tick(NV);
        wait_until(last_t + 6);
        cfg_we = 1'b1; cfg_voice = 8'd2; cfg_increment = 24'h300000; cfg_wave = 4'd7; cfg_gate = 1'b0;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        model_cfg(8'd2, 24'h300000, 4'd7, 1'b0);
        wait_frame();
        check("collide_old", seen_phase[2], 64);
        do_tick(NV);
        wait_frame();
        check("collide_next", seen_phase[2], 0);

        // Reset at T+8: only voices 0..2 emitted, nothing afterwards.
        do_tick(3);
        wait_until(last_t + 8);
        reset = 1'b1;
        model_clear();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        check("reset_flush", exp_q.size(), 0);
        @(negedge clk);
        check("reset_phase", phase, 0);
        check("reset_busy", frame_busy, 0);
        cfg_write(8'd3, 24'h040000, 4'd1, 1'b1);
        do_tick(NV);
        wait_frame();
        check("restart_v3_0", seen_phase[3], 0);
        do_tick(NV);
        wait_frame();
        check("restart_v3_1", seen_phase[3], 16);

        check("queue_empty", exp_q.size() + ovr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
